vga_timing_engine: RTL and testbench
====================================

# vga_timing_engine

Generates 640x480@60 Hz VGA raster timing from a pixel-rate enable strobe and drives the VGA DAC pins. It sits directly downstream of the pattern/colour generators. It publishes the current pixel coordinate, samples the generator's 8-bit RGB for that coordinate, and emits RGB, HSYNC, VSYNC, BLANK and SYNC aligned to one another. A one-clock frame-start pulse lets upstream logic update per-frame state, such as animated colours, between frames.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  pixel strobe; all pixel-rate state advances only on clock edges with enable=1
- iRed, iGreen, iBlue  in  8 each  upstream colour for the coordinate currently on oCoord_X/oCoord_Y
- oCoord_X  out  10  current horizontal count h_cnt (0..H_TOTAL-1)
- oCoord_Y  out  10  current vertical count v_cnt (0..V_TOTAL-1)
- oVGA_R, oVGA_G, oVGA_B  out  8 each  registered pixel colour
- oVGA_H_SYNC  out  1  horizontal sync, active low
- oVGA_V_SYNC  out  1  vertical sync, active low
- oVGA_BLANK  out  1  high during visible pixels, low while blanking
- oVGA_SYNC  out  1  composite sync; tied to 0
- oFrame_start  out  1  one-clock pulse at the start of each frame

## Operation
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both must be ≤ 1024; violating this is a parameter error.
- Line order is visible, front porch, sync, back porch, on both axes.
- Counters, on each clock edge with enable=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 on the same edge that h_cnt wraps.
- visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE), evaluated on the current counter values.
- Output stage, on the same enable edge:
  - RGB ← visible ? iRGB : 0.
  - H_SYNC ← ~(H_VISIBLE+H_FRONT ≤ h_cnt < H_VISIBLE+H_FRONT+H_SYNC), i.e. low for h_cnt 656..751.
  - V_SYNC ← ~(V_VISIBLE+V_FRONT ≤ v_cnt < V_VISIBLE+V_FRONT+V_SYNC), i.e. low for v_cnt 490..491.
  - BLANK ← visible.
- Upstream contract: upstream sees the coordinate for a full pixel period and must present stable iRGB for it by the next enable edge. Upstream must ignore coordinates outside the visible region; any colour it supplies there is discarded.
- oFrame_start: registered; high for exactly one clock after the enable edge that loads h_cnt=0, v_cnt=0.
- With enable=0, every register holds its value.

## Timing
- Reset values: h_cnt=0, v_cnt=0, RGB=0, H_SYNC=1, V_SYNC=1, BLANK=0, SYNC=0, oFrame_start=0. Reset takes effect asynchronously.
- Reset released mid-frame: the raster restarts at (0,0). No oFrame_start is issued for the post-reset frame; the first pulse occurs at the next (0,0) wrap.
- Latency: RGB, HSYNC, VSYNC and BLANK lag oCoord by exactly one pixel (one enable edge). All four change on the same clock edge.
- With enable toggling every clock (25 MHz pixel rate):
  - line = 1600 clocks; frame = 840,000 clocks;
  - HSYNC low for 192 clocks; VSYNC low for 2 lines = 3200 clocks.
- enable held at 1 is legal: identical sequence at one pixel per clock.
- Simultaneous h and v wrap at (799,524) → (0,0): the V_SYNC and BLANK updates on that edge use the pre-wrap values (524 → V_SYNC=1, BLANK=0).

## Test plan
- Reset then toggle enable: oCoord goes 0,1,2…; first visible pixel appears on outputs one enable edge after (0,0); BLANK rises there; oVGA_SYNC stays 0 throughout.
- Full line: with iRGB=FF/00/00 constant, R=FF for exactly 640 pixels. H_SYNC falls one pixel after h_cnt=656 and stays low 96 pixels (192 clocks). BLANK low for 160 pixels.
- Full frame: count enable edges between oFrame_start pulses = 420,000. V_SYNC is low for exactly 1600 pixels starting one pixel after (0,490). RGB=0 on all lines with v ≥ 480 despite iRGB=FFFFFF.
- Enable stall: hold enable=0 for 50 clocks mid-line at h=300. Counters and all outputs frozen, then resume at h=301 with no skipped or duplicated pixel.
- Reset mid-frame at (400,250): outputs immediately return to reset values (H_SYNC=V_SYNC=1, RGB=0). After release the count restarts at (0,0), and no oFrame_start appears until 420,000 enable edges later.
- Coordinate-keyed input: drive iRed = oCoord_X[7:0] combinationally. Output R equals (previous X)[7:0] for every visible pixel, confirming the one-pixel alignment.

Source files
------------

// File: rtl/vga_timing_engine.sv
// vga_timing_engine
// 640x480@60 raster timing driven by a pixel-rate enable strobe. Publishes the
// current coordinate to upstream generators, samples their colour for that
// coordinate, and registers RGB/HSYNC/VSYNC/BLANK so all four move together
// one pixel behind oCoord_X/oCoord_Y.
module vga_timing_engine #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] iRed,
  input  logic [7:0] iGreen,
  input  logic [7:0] iBlue,
  output logic [9:0] oCoord_X,
  output logic [9:0] oCoord_Y,
  output logic [7:0] oVGA_R,
  output logic [7:0] oVGA_G,
  output logic [7:0] oVGA_B,
  output logic       oVGA_H_SYNC,
  output logic       oVGA_V_SYNC,
  output logic       oVGA_BLANK,
  output logic       oVGA_SYNC,
  output logic       oFrame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

  // Counters are 10 bits wide; a larger raster cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_err
    $error("vga_timing_engine: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic       fs_q, fs_d;

  logic       h_last, v_last;
  logic       visible, hs_active, vs_active;

  // Decode the current (pre-edge) coordinate: wrap points, visibility, sync windows.
  always_comb begin
    h_last    = (h_cnt_q == 10'(H_TOTAL - 1));
    v_last    = (v_cnt_q == 10'(V_TOTAL - 1));
    visible   = (h_cnt_q < 10'(H_VISIBLE)) && (v_cnt_q < 10'(V_VISIBLE));
    hs_active = (h_cnt_q >= 10'(HS_START)) && (h_cnt_q < 10'(HS_END));
    vs_active = (v_cnt_q >= 10'(VS_START)) && (v_cnt_q < 10'(VS_END));
  end

  // Next raster position: h advances each pixel, v advances when h wraps.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (enable) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Next output stage: built from the pre-edge coordinate so that the DAC
  // pins lag oCoord by exactly one pixel, including on the (last,last) wrap.
  always_comb begin
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    // The frame pulse is one clock wide regardless of the pixel strobe.
    fs_d    = 1'b0;
    if (enable) begin
      r_d     = visible ? iRed   : 8'd0;
      g_d     = visible ? iGreen : 8'd0;
      b_d     = visible ? iBlue  : 8'd0;
      hs_d    = ~hs_active;
      vs_d    = ~vs_active;
      blank_d = visible;
      fs_d    = h_last && v_last;
    end
  end

  // Raster counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Registered DAC outputs and frame-start pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  end

  assign oCoord_X     = h_cnt_q;
  assign oCoord_Y     = v_cnt_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_H_SYNC  = hs_q;
  assign oVGA_V_SYNC  = vs_q;
  assign oVGA_BLANK   = blank_q;
  assign oVGA_SYNC    = 1'b0;
  assign oFrame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine: one full-size 640x480 instance (line-level
// behaviour) and one shrunken-geometry instance (frame-level behaviour),
// both fed the same enable/reset/colour stream and compared every clock
// against a pixel-count reference model, plus a constant table and a few
// hand-written sequences.
module tb_vga_timing_engine;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } geom_t;

  typedef struct {
    int         x, y;
    logic [7:0] r, g, b;
    logic       hs, vs, bl, fs;
  } exp_t;

  typedef struct {
    int   n;            // enable edges since reset
    int   x, y;
    logic hs, vs, bl, fs;
  } vec_t;

  localparam geom_t GA = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam geom_t GB = '{16, 4, 6, 4, 8, 2, 2, 3};
  localparam int FT_A = 800 * 525;
  localparam int FT_B = 30 * 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [7:0] iG = 8'd0, iB = 8'd0;

  logic [7:0] iR_a, iR_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic hs_a, vs_a, bl_a, sy_a, fs_a;
  logic hs_b, vs_b, bl_b, sy_b, fs_b;

  int checks = 0;
  int errors = 0;

  // Upstream generator: colour keyed to the published coordinate.
  assign iR_a = x_a[7:0];
  assign iR_b = x_b[7:0];

  vga_timing_engine u_a (
    .clock(clk), .reset(rst), .enable(en),
    .iRed(iR_a), .iGreen(iG), .iBlue(iB),
    .oCoord_X(x_a), .oCoord_Y(y_a),
    .oVGA_R(r_a), .oVGA_G(g_a), .oVGA_B(b_a),
    .oVGA_H_SYNC(hs_a), .oVGA_V_SYNC(vs_a), .oVGA_BLANK(bl_a),
    .oVGA_SYNC(sy_a), .oFrame_start(fs_a)
  );

  vga_timing_engine #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_b (
    .clock(clk), .reset(rst), .enable(en),
    .iRed(iR_b), .iGreen(iG), .iBlue(iB),
    .oCoord_X(x_b), .oCoord_Y(y_b),
    .oVGA_R(r_b), .oVGA_G(g_b), .oVGA_B(b_b),
    .oVGA_H_SYNC(hs_b), .oVGA_V_SYNC(vs_b), .oVGA_BLANK(bl_b),
    .oVGA_SYNC(sy_b), .oFrame_start(fs_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from n, the number of pixel edges
  // since reset. The coordinate is pixel n; the outputs describe pixel n-1.
  function automatic exp_t model(geom_t gm, int n, logic [7:0] g, logic [7:0] b, logic fs);
    exp_t e;
    int ht, vt, ph, pv;
    logic vis;
    ht = gm.hv + gm.hf + gm.hs + gm.hb;
    vt = gm.vv + gm.vf + gm.vs + gm.vb;
    e.x = n % ht;
    e.y = (n / ht) % vt;
    e.fs = fs;
    if (n == 0) begin
      e.r = 0; e.g = 0; e.b = 0; e.hs = 1; e.vs = 1; e.bl = 0;
    end else begin
      ph  = (n - 1) % ht;
      pv  = ((n - 1) / ht) % vt;
      vis = (ph < gm.hv) && (pv < gm.vv);
      e.r  = vis ? ph[7:0] : 8'd0;
      e.g  = vis ? g : 8'd0;
      e.b  = vis ? b : 8'd0;
      e.hs = !((ph >= gm.hv + gm.hf) && (ph < gm.hv + gm.hf + gm.hs));
      e.vs = !((pv >= gm.vv + gm.vf) && (pv < gm.vv + gm.vf + gm.vs));
      e.bl = vis;
    end
    return e;
  endfunction

  int         n_m = 0;
  logic [7:0] lg = 8'd0, lb = 8'd0;
  logic       fsA_m = 1'b0, fsB_m = 1'b0;

  // Model state: pixel count, last sampled green/blue, frame pulses.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_m <= 0; lg <= 8'd0; lb <= 8'd0; fsA_m <= 1'b0; fsB_m <= 1'b0;
    end else begin
      fsA_m <= 1'b0;
      fsB_m <= 1'b0;
      if (en) begin
        n_m   <= n_m + 1;
        lg    <= iG;
        lb    <= iB;
        fsA_m <= ((n_m + 1) % FT_A) == 0;
        fsB_m <= ((n_m + 1) % FT_B) == 0;
      end
    end
  end

  // Scoreboard: compare both instances every clock, between edges.
  always @(posedge clk) begin
    exp_t ea, eb;
    #3;
    ea = model(GA, n_m, lg, lb, fsA_m);
    eb = model(GB, n_m, lg, lb, fsB_m);
    chk("a_x", int'(x_a), ea.x);   chk("a_y", int'(y_a), ea.y);
    chk("a_r", int'(r_a), int'(ea.r)); chk("a_g", int'(g_a), int'(ea.g));
    chk("a_b", int'(b_a), int'(ea.b));
    chk("a_hs", int'(hs_a), int'(ea.hs)); chk("a_vs", int'(vs_a), int'(ea.vs));
    chk("a_bl", int'(bl_a), int'(ea.bl)); chk("a_fs", int'(fs_a), int'(ea.fs));
    chk("a_sync", int'(sy_a), 0);
    chk("b_x", int'(x_b), eb.x);   chk("b_y", int'(y_b), eb.y);
    chk("b_r", int'(r_b), int'(eb.r)); chk("b_g", int'(g_b), int'(eb.g));
    chk("b_b", int'(b_b), int'(eb.b));
    chk("b_hs", int'(hs_b), int'(eb.hs)); chk("b_vs", int'(vs_b), int'(eb.vs));
    chk("b_bl", int'(bl_b), int'(eb.bl)); chk("b_fs", int'(fs_b), int'(eb.fs));
    chk("b_sync", int'(sy_b), 0);
  end

  initial begin
    vec_t tab[14];
    int cnt;
    logic [9:0] fx, fy;
    logic [7:0] fr;
    logic fh, fbl;

    // Shrunken geometry: H 16/4/6/4 (total 30, hsync low 20..25),
    // V 8/2/2/3 (total 15, vsync low 10..11), frame 450 pixels.
    tab[0]  = '{0,   0,  0, 1, 1, 0, 0};
    tab[1]  = '{1,   1,  0, 1, 1, 1, 0};
    tab[2]  = '{16,  16, 0, 1, 1, 1, 0};
    tab[3]  = '{17,  17, 0, 1, 1, 0, 0};
    tab[4]  = '{20,  20, 0, 1, 1, 0, 0};
    tab[5]  = '{21,  21, 0, 0, 1, 0, 0};
    tab[6]  = '{26,  26, 0, 0, 1, 0, 0};
    tab[7]  = '{27,  27, 0, 1, 1, 0, 0};
    tab[8]  = '{30,  0,  1, 1, 1, 0, 0};
    tab[9]  = '{241, 1,  8, 1, 1, 0, 0};
    tab[10] = '{301, 1, 10, 1, 0, 0, 0};
    tab[11] = '{361, 1, 12, 1, 1, 0, 0};
    tab[12] = '{450, 0,  0, 1, 1, 0, 1};
    tab[13] = '{451, 1,  0, 1, 1, 1, 0};

    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      while (cnt < tab[i].n) begin
        en = 1'b1;
        @(negedge clk);
        cnt++;
      end
      en = 1'b0;
      chk("tab_x",  int'(x_b),  tab[i].x);
      chk("tab_y",  int'(y_b),  tab[i].y);
      chk("tab_hs", int'(hs_b), int'(tab[i].hs));
      chk("tab_vs", int'(vs_b), int'(tab[i].vs));
      chk("tab_bl", int'(bl_b), int'(tab[i].bl));
      chk("tab_fs", int'(fs_b), int'(tab[i].fs));
      @(negedge clk);
    end

    // Stall at h=300 on the full-size raster: nothing moves for 50 clocks.
    for (int k = 0; k < 2000 && x_a != 10'd300; k++) begin
      en = 1'b1;
      @(negedge clk);
    end
    en = 1'b0;
    chk("stall_reach", int'(x_a), 300);
    fx = x_a; fy = y_a; fr = r_a; fh = hs_a; fbl = bl_a;
    repeat (50) begin
      @(negedge clk);
      chk("stall_x", int'(x_a), int'(fx));
      chk("stall_r", int'(r_a), int'(fr));
      chk("stall_bl", int'(bl_a), int'(fbl));
      chk("stall_hs", int'(hs_a), int'(fh));
      chk("stall_y", int'(y_a), int'(fy));
    end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("resume_x", int'(x_a), 301);
    chk("resume_r", int'(r_a), 44);   // pixel 300 -> 300 mod 256

    // Mid-line reset at h=400: outputs drop to reset values immediately.
    for (int k = 0; k < 2000 && x_a != 10'd400; k++) begin
      en = 1'b1;
      @(negedge clk);
    end
    en = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_x", int'(x_a), 0);
    chk("rst_r", int'(r_a), 0);
    chk("rst_hs", int'(hs_a), 1);
    chk("rst_vs", int'(vs_a), 1);
    chk("rst_bl", int'(bl_a), 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 24000; c++) begin
      @(negedge clk);
      en  = ($urandom_range(0, 99) < 75);
      iG  = 8'($urandom);
      iB  = 8'($urandom);
      rst = ($urandom_range(0, 4999) == 0);
    end
    rst = 1'b0;

    // Continuous enable: one pixel per clock.
    en = 1'b1;
    repeat (2000) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
